// File: rtl/uart_pkg.sv
// uart_pkg: shared UART scheduler defaults, frame timing derivations and FSM encoding.
package uart_pkg;
   localparam int SYS_CLK_FRE_DEF = 50_000_000;
   localparam int BPS_DEF         = 9_600;
   localparam int EN_HOLD_DEF     = 3;
   typedef enum logic {IDLE, SEND} state_t;
   function automatic int bps_cnt(input int sys_clk_fre, input int bps);
      return sys_clk_fre / bps;
   endfunction
   // ten bit periods plus two cycles for the transmitter's edge detector
   function automatic int frame_cyc(input int sys_clk_fre, input int bps);
      return 10 * bps_cnt(sys_clk_fre, bps) + 2;
   endfunction
endpackage

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-way round-robin pick, search starting at ptr.
module rr_arbiter4 (
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   output logic [3:0] gnt,
   output logic [1:0] gnt_id
);
   logic [1:0] w_idx;
   always_comb begin
      gnt_id = ptr;
      w_idx  = ptr;
      for (int k = 3; k >= 0; k--) begin
         w_idx = ptr + 2'(k);
         if (req[w_idx]) gnt_id = w_idx;
      end
      gnt = (|req) ? 4'b0001 << gnt_id : 4'b0000;
   end
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin byte scheduler feeding a UART transmitter one frame at a time.
module uart_tx_sched
   import uart_pkg::*;
#(
   parameter int SYS_CLK_FRE = SYS_CLK_FRE_DEF,
   parameter int BPS         = BPS_DEF,
   parameter int EN_HOLD     = EN_HOLD_DEF
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic [3:0]  req_valid,
   input  logic [31:0] req_data,
   output logic [3:0]  req_ready,
   output logic [7:0]  uart_data,
   output logic        uart_tx_en,
   output logic        busy,
   output logic [1:0]  grant_id
);
   localparam int FRAME_CYC = frame_cyc(SYS_CLK_FRE, BPS);
   // one spare bit so the timer can never wrap inside a frame
   localparam int TW = $clog2(FRAME_CYC + 1) + 1;
   state_t          r_state;
   logic [1:0]      r_ptr;
   logic [TW-1:0]   r_timer;
   logic [3:0]      w_gnt;
   logic [1:0]      w_gnt_id;
   rr_arbiter4 u_arb (
      .req    (req_valid),
      .ptr    (r_ptr),
      .gnt    (w_gnt),
      .gnt_id (w_gnt_id)
   );
   assign req_ready = (r_state == IDLE && sys_rst_n) ? w_gnt : 4'b0000;
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state    <= IDLE;
         r_ptr      <= 2'd0;
         r_timer    <= '0;
         uart_data  <= 8'h00;
         uart_tx_en <= 1'b0;
         busy       <= 1'b0;
         grant_id   <= 2'd0;
      end else if (r_state == IDLE) begin
         if (|req_valid) begin
            r_state    <= SEND;
            r_ptr      <= w_gnt_id + 2'd1;
            r_timer    <= '0;
            uart_data  <= req_data[{w_gnt_id, 3'b000} +: 8];
            uart_tx_en <= 1'b1;
            busy       <= 1'b1;
            grant_id   <= w_gnt_id;
         end
      end else begin
         r_timer    <= r_timer + 1'b1;
         uart_tx_en <= r_timer < TW'(EN_HOLD - 1);
         if (r_timer == TW'(FRAME_CYC - 1)) begin
            r_state <= IDLE;
            busy    <= 1'b0;
         end
      end
   end
endmodule
